// File: rtl/tcam_ctrl.sv
// Sequencer/arbiter in front of a TCAM array: lookup vs update sharing, sweep-clear, registered priority-encoded response.
// Optional TCAM_CTRL_MULTIHIT_EN builds the multi-hit flag; otherwise rsp_multi is tied 0.
//
// state  | meaning
// IDLE   | arbitrate clr_start / lookup / update, readies live here only
// WRITE  | one array write of the accepted update
// SEARCH | tcam_read strobe with key/mask on A/K
// WAIT   | array settling; matched vector captured at the end
// RESP   | rsp_valid held until rsp_ready
// CLEAR  | sweep every entry with A=0, K=all ones
module tcam_ctrl #(
   parameter int WORD_WIDTH  = 16,
   parameter int MEMORY_SIZE = 32,
   localparam int AW         = $clog2(MEMORY_SIZE)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   lk_valid,
   output logic                   lk_ready,
   input  logic [WORD_WIDTH-1:0]  lk_key,
   input  logic [WORD_WIDTH-1:0]  lk_mask,
   input  logic                   up_valid,
   output logic                   up_ready,
   input  logic [AW-1:0]          up_addr,
   input  logic [WORD_WIDTH-1:0]  up_data,
   input  logic [WORD_WIDTH-1:0]  up_mask,
   input  logic                   clr_start,
   output logic                   busy,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_hit,
   output logic [AW-1:0]          rsp_index,
   output logic                   rsp_multi,
   output logic [WORD_WIDTH-1:0]  tcam_A,
   output logic [WORD_WIDTH-1:0]  tcam_K,
   output logic [AW-1:0]          tcam_write_addr,
   output logic                   tcam_read,
   output logic                   tcam_write,
   input  logic [MEMORY_SIZE-1:0] tcam_matched
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WRITE  = 3'd1,
      SEARCH = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4,
      CLEAR  = 3'd5
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(MEMORY_SIZE - 1);

   state_t                state_q, state_d;
   logic                  rr_q, rr_d;
   logic                  ready_en_q;
   logic [WORD_WIDTH-1:0] a_q, a_d;
   logic [WORD_WIDTH-1:0] k_q, k_d;
   logic [AW-1:0]         waddr_q, waddr_d;
   logic                  hit_q, hit_d;
   logic [AW-1:0]         index_q, index_d;
   logic [AW-1:0]         enc_idx;
   logic                  lk_grant, up_grant, contested;

   // Readies stay low while reset is asserted and come up one edge after release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rr_q       <= 1'b0;
         ready_en_q <= 1'b0;
         a_q        <= '0;
         k_q        <= '0;
         waddr_q    <= '0;
         hit_q      <= 1'b0;
         index_q    <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         ready_en_q <= 1'b1;
         a_q        <= a_d;
         k_q        <= k_d;
         waddr_q    <= waddr_d;
         hit_q      <= hit_d;
         index_q    <= index_d;
      end
   end

   always_comb begin
      enc_idx = '0;
      for (int i = MEMORY_SIZE - 1; i >= 0; i--) begin
         if (tcam_matched[i]) enc_idx = AW'(i);
      end
   end

   // rr_q=0 favours lookup on a contested cycle.
   assign contested = lk_valid && up_valid;
   assign lk_grant  = lk_valid && (!up_valid || !rr_q);
   assign up_grant  = up_valid && (!lk_valid || rr_q);

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      a_d        = a_q;
      k_d        = k_q;
      waddr_d    = waddr_q;
      hit_d      = hit_q;
      index_d    = index_q;
      lk_ready   = 1'b0;
      up_ready   = 1'b0;
      tcam_read  = 1'b0;
      tcam_write = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr_start) begin
               state_d = CLEAR;
               a_d     = '0;
               k_d     = '1;
               waddr_d = '0;
            end else begin
               lk_ready = ready_en_q && !up_grant;
               up_ready = ready_en_q && !lk_grant;
               if (lk_valid && lk_ready) begin
                  state_d = SEARCH;
                  a_d     = lk_key;
                  k_d     = lk_mask;
                  if (contested) rr_d = ~rr_q;
               end else if (up_valid && up_ready) begin
                  state_d = WRITE;
                  a_d     = up_data;
                  k_d     = up_mask;
                  waddr_d = up_addr;
                  if (contested) rr_d = ~rr_q;
               end
            end
         end
         WRITE: begin
            tcam_write = 1'b1;
            state_d    = IDLE;
         end
         SEARCH: begin
            tcam_read = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            state_d = RESP;
            hit_d   = |tcam_matched;
            index_d = enc_idx;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         CLEAR: begin
            tcam_write = 1'b1;
            if (waddr_q == LAST_ADDR) state_d = IDLE;
            else                      waddr_d = waddr_q + AW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef TCAM_CTRL_MULTIHIT_EN
   logic multi_q, multi_d;

   // Two or more bits set iff clearing the lowest set bit leaves something.
   always_comb begin
      multi_d = multi_q;
      if (state_q == WAIT)
         multi_d = |(tcam_matched & (tcam_matched - MEMORY_SIZE'(1)));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) multi_q <= 1'b0;
      else       multi_q <= multi_d;
   end

   assign rsp_multi = multi_q;
`else
   assign rsp_multi = 1'b0;
`endif

   assign busy            = (state_q != IDLE);
   assign rsp_valid       = (state_q == RESP);
   assign rsp_hit         = hit_q;
   assign rsp_index       = index_q;
   assign tcam_A          = a_q;
   assign tcam_K          = k_q;
   assign tcam_write_addr = waddr_q;

endmodule

// File: tb/tb_tcam_ctrl.sv
// Directed bench for tcam_ctrl: vector table of lookups plus clear, update, arbitration and reset sequences.
module tb_tcam_ctrl;

`ifdef TCAM_CTRL_MULTIHIT_EN
   localparam bit MULTI_EN = 1'b1;
`else
   localparam bit MULTI_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        lk_valid = 1'b0, lk_ready;
   logic [15:0] lk_key = '0, lk_mask = '0;
   logic        up_valid = 1'b0, up_ready;
   logic [4:0]  up_addr = '0;
   logic [15:0] up_data = '0, up_mask = '0;
   logic        clr_start = 1'b0;
   logic        busy, rsp_valid, rsp_hit, rsp_multi;
   logic        rsp_ready = 1'b0;
   logic [4:0]  rsp_index, tcam_write_addr;
   logic [15:0] tcam_A, tcam_K;
   logic        tcam_read, tcam_write;
   logic [31:0] tcam_matched = '0;

   int checks = 0;
   int errors = 0;

   tcam_ctrl #(.WORD_WIDTH(16), .MEMORY_SIZE(32)) dut (
      .clk(clk), .reset(reset),
      .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key), .lk_mask(lk_mask),
      .up_valid(up_valid), .up_ready(up_ready), .up_addr(up_addr), .up_data(up_data), .up_mask(up_mask),
      .clr_start(clr_start), .busy(busy),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_index(rsp_index),
      .rsp_multi(rsp_multi),
      .tcam_A(tcam_A), .tcam_K(tcam_K), .tcam_write_addr(tcam_write_addr),
      .tcam_read(tcam_read), .tcam_write(tcam_write), .tcam_matched(tcam_matched)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] key;
      logic [15:0] mask;
      logic [31:0] matched;
      logic        hit;
      logic [4:0]  idx;
      logic        multi;
      int          stall;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {14'd0, lk_ready, up_ready, busy, rsp_valid, rsp_hit, rsp_index, rsp_multi,
              tcam_read, tcam_write, tcam_write_addr, tcam_A, tcam_K};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_lookup(input vec_t v, input int n);
      int t;
      logic [63:0] held;
      string tag;
      tag = $sformatf("lk%0d", n);
      lk_key = v.key; lk_mask = v.mask; lk_valid = 1'b1; rsp_ready = 1'b0; tcam_matched = '0;
      #1;
      t = 0;
      while (!lk_ready && t < 20) begin tick(); t++; end
      chk({tag, "_ready"}, lk_ready, 1);
      tick();
      lk_valid = 1'b0;
      chk({tag, "_search"}, {tcam_read, tcam_write, rsp_valid}, 3'b100);
      chk({tag, "_ak"}, {tcam_A, tcam_K}, {v.key, v.mask});
      tcam_matched = v.matched;
      tick();
      chk({tag, "_wait"}, {tcam_read, tcam_write, rsp_valid, tcam_A, tcam_K}, {3'b000, v.key, v.mask});
      tick();
      tcam_matched = 32'h5555_5555;
      chk({tag, "_rsp"}, {rsp_valid, rsp_hit, rsp_index, rsp_multi},
          {1'b1, v.hit, v.idx, v.multi & MULTI_EN});
      held = {busy, rsp_valid, rsp_hit, rsp_index, rsp_multi};
      for (int s = 0; s < v.stall; s++) begin
         lk_valid = 1'b1;
         up_valid = 1'b1;
         tick();
         chk({tag, "_stall"}, {busy, rsp_valid, rsp_hit, rsp_index, rsp_multi}, held);
         chk({tag, "_stall_rdy"}, {lk_ready, up_ready}, 2'b00);
      end
      lk_valid = 1'b0;
      up_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      tcam_matched = '0;
      chk({tag, "_done"}, {rsp_valid, busy}, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int g, cyc, clash, dual, t;
      logic grants[4];

      vecs[0] = '{16'h00AB, 16'h00FF, 32'h0000_0020, 1'b1, 5'd5,  1'b0, 0};
      vecs[1] = '{16'h1234, 16'hFFFF, 32'h8000_0010, 1'b1, 5'd4,  1'b1, 0};
      vecs[2] = '{16'h0000, 16'h0000, 32'h0000_0000, 1'b0, 5'd0,  1'b0, 4};
      vecs[3] = '{16'hBEEF, 16'h0F0F, 32'h8000_0000, 1'b1, 5'd31, 1'b0, 0};
      vecs[4] = '{16'h0001, 16'h0001, 32'h0000_0001, 1'b1, 5'd0,  1'b0, 1};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 1'b1, 5'd0,  1'b1, 0};
      vecs[6] = '{16'hA5A5, 16'h00F0, 32'h0001_0100, 1'b1, 5'd8,  1'b1, 2};

      // Reset state
      #2;
      chk("reset_outs", all_outs(), 64'd0);
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("idle_ready", {lk_ready, up_ready, busy, rsp_valid}, 4'b1100);

      // Sweep clear, with a redundant clr_start mid-sweep that must be ignored
      clr_start = 1'b1;
      #1;
      chk("clr_blocks_ready", {lk_ready, up_ready}, 2'b00);
      tick();
      clr_start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         clr_start = (i == 10);
         chk($sformatf("clr_%0d", i), {tcam_write, tcam_read, busy, tcam_write_addr, tcam_A, tcam_K},
             {3'b101, 5'(i), 16'h0000, 16'hFFFF});
         tick();
      end
      clr_start = 1'b0;
      chk("clr_end", {tcam_write, busy}, 2'b00);
      tick();
      chk("clr_not_queued", {tcam_write, busy}, 2'b00);

      // Update addr 5
      up_addr = 5'd5; up_data = 16'h00AB; up_mask = 16'h00FF; up_valid = 1'b1;
      #1;
      chk("up_ready", up_ready, 1);
      tick();
      up_valid = 1'b0;
      chk("up_write", {tcam_write, tcam_read, busy, tcam_write_addr, tcam_A, tcam_K},
          {3'b101, 5'd5, 16'h00AB, 16'h00FF});
      tick();
      chk("up_done", {tcam_write, busy, up_ready}, 3'b001);

      // Lookup vector table
      for (int n = 0; n < 7; n++) run_lookup(vecs[n], n);

      // Contested arbitration
      lk_key = 16'h0042; lk_mask = 16'hFFFF; tcam_matched = 32'h0000_0004;
      up_addr = 5'd7; up_data = 16'h1111; up_mask = 16'h2222;
      rsp_ready = 1'b1; lk_valid = 1'b1; up_valid = 1'b1;
      g = 0; cyc = 0; clash = 0; dual = 0;
      #1;
      while (g < 4 && cyc < 80) begin
         if (tcam_read && tcam_write) clash++;
         if (lk_ready && up_ready) dual++;
         if (lk_ready) begin grants[g] = 1'b0; g++; end
         else if (up_ready) begin grants[g] = 1'b1; g++; end
         tick();
         cyc++;
      end
      lk_valid = 1'b0; up_valid = 1'b0;
      t = 0;
      while (busy && t < 20) begin
         if (tcam_read && tcam_write) clash++;
         tick();
         t++;
      end
      rsp_ready = 1'b0;
      chk("arb_grants", g, 4);
      chk("arb_order", {grants[0], grants[1], grants[2], grants[3]}, 4'b0101);
      chk("arb_dual_ready", dual, 0);
      chk("arb_rd_wr_clash", clash, 0);
      chk("arb_drain", busy, 0);

      // Reset asserted during WAIT
      lk_key = 16'hFFFF; lk_mask = 16'hF0F0; lk_valid = 1'b1;
      #1;
      chk("rst_pre_ready", lk_ready, 1);
      tick();
      lk_valid = 1'b0;
      tick();
      chk("rst_in_wait", {busy, tcam_read, rsp_valid}, 3'b100);
      tcam_matched = 32'h0000_0001;
      reset = 1'b1;
      #1;
      chk("rst_async_outs", all_outs(), 64'd0);
      tick();
      chk("rst_held_outs", all_outs(), 64'd0);
      reset = 1'b0;
      tick();
      chk("rst_release", {lk_ready, up_ready, busy, rsp_valid, rsp_hit}, 5'b11000);
      tick();
      tick();
      chk("rst_no_stale_rsp", {rsp_valid, busy}, 2'b00);
      tcam_matched = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tcam_ctrl.md
Name: tcam_ctrl

Overview:
- Sequencer and arbiter placed in front of a TCAM array: WORD_WIDTH bits per entry, MEMORY_SIZE entries, with `read`/`write`/`write_addr` control and a per-entry `matched` vector.
- Shares the array between a lookup requester and an update (write) requester, and provides a sweep-clear command.
- Priority-encodes the match vector into a registered hit/index response with valid/ready handshakes.

Parameters:
- WORD_WIDTH, 16: key/mask width.
- MEMORY_SIZE, 32: number of TCAM entries. Power of 2, ≥2.
- AW, $clog2(MEMORY_SIZE): address/index width (localparam).

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- lk_valid  in  1  lookup request valid
- lk_ready  out  1  lookup request accepted when lk_valid&&lk_ready
- lk_key  in  WORD_WIDTH  search key (drives A)
- lk_mask  in  WORD_WIDTH  search mask (drives K)
- up_valid  in  1  update request valid
- up_ready  out  1  update accepted when up_valid&&up_ready
- up_addr  in  AW  entry to write
- up_data  in  WORD_WIDTH  entry value (A)
- up_mask  in  WORD_WIDTH  entry mask (K)
- clr_start  in  1  pulse: clear all entries
- busy  out  1  state != IDLE
- rsp_valid  out  1  lookup result valid
- rsp_ready  in  1  result consumed when rsp_valid&&rsp_ready
- rsp_hit  out  1  at least one entry matched
- rsp_index  out  AW  lowest matching index (0 when no hit)
- rsp_multi  out  1  more than one entry matched (optional feature)
- tcam_A  out  WORD_WIDTH  to array A
- tcam_K  out  WORD_WIDTH  to array K
- tcam_write_addr  out  AW  to array write_addr
- tcam_read  out  1  to array read
- tcam_write  out  1  to array write
- tcam_matched  in  MEMORY_SIZE  from array matched

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all outputs 0.
  - Round-robin pointer favours lookup first.
  - tcam_A/K/write_addr/read/write = 0.
- States:
  - IDLE, WRITE, SEARCH, WAIT, RESP, CLEAR.
- IDLE:
  - lk_ready = up_ready = 1 only in IDLE with clr_start low. Both are 0 in every other state.
- Arbitration in IDLE, one grant per cycle:
  - clr_start beats everything.
  - Otherwise, if only one requester is valid, grant it.
  - If both are valid, alternate grants using a 1-bit pointer that toggles after each contested grant.
  - Ungranted ready is 0 that cycle.
- Lookup flow:
  - Accept edge: key and mask are registered onto tcam_A/tcam_K.
  - SEARCH (1 cycle): tcam_read=1.
  - WAIT (1 cycle): tcam_A/K are held; at the end of WAIT, tcam_matched is sampled, encoded and registered.
  - RESP: rsp_valid=1 until rsp_ready, then IDLE.
  - Latency: rsp_valid rises 3 edges after accept. Response fields are stable while rsp_valid && !rsp_ready.
  - rsp_ready held high returns to IDLE on the first RESP cycle.
- Update flow:
  - Accept edge registers addr/data/mask.
  - WRITE (1 cycle): tcam_write=1, tcam_A=data, tcam_K=mask, tcam_write_addr=addr.
  - Then IDLE, so an update takes 2 cycles.
- CLEAR:
  - Counter 0..MEMORY_SIZE-1, one write per cycle, tcam_write=1.
  - tcam_K = all ones, tcam_A = 0.
  - Returns to IDLE after the last index; the counter does not wrap. Duration: MEMORY_SIZE cycles.
  - clr_start while not IDLE is ignored (not queued).
- Encoding:
  - rsp_hit = |matched.
  - rsp_index = lowest set bit index.
  - All-zero vector gives hit=0, index=0.
- tcam_read and tcam_write are never high in the same cycle.
- Mid-operation reset: abort immediately; any pending response is lost; strobes deassert asynchronously.

Optional Feature:
- Macro: TCAM_CTRL_MULTIHIT_EN.
- Defined: rsp_multi = 1 when popcount(matched) ≥ 2, registered with rsp_hit.
- Undefined: the port exists and is tied 0; no popcount logic is built.

Test Plan:
- Reset then clr_start pulse:
  - tcam_write high for exactly 32 cycles with addr 0..31, K=FFFF, A=0000.
  - busy drops on cycle 33.
- Update addr=5, data=00AB, mask=00FF; then lookup key=00AB, mask=00FF with the array returning matched=0x0000_0020:
  - rsp_valid appears 3 edges after accept.
  - hit=1, index=5.
- Lookup with matched=0x8000_0010:
  - index=4, hit=1.
  - rsp_multi=1 (macro defined) or 0 (undefined).
- Lookup with matched=0:
  - hit=0, index=0.
  - rsp_ready held low for 4 cycles: outputs stable; lk_ready=0 throughout.
- lk_valid and up_valid held high together for 4 grants:
  - Grant order is lookup, update, lookup, update.
  - tcam_read and tcam_write are never simultaneous.
- Assert reset during WAIT:
  - All outputs 0 immediately.
  - After release: IDLE, lk_ready=1, no stale rsp_valid.
